// File: rtl/image_resize_avg_pkg.sv
// Shared constants and state encoding for the block-average frame downscaler.
package image_resize_avg_pkg;

    localparam int SRC_W_DEF = 640;
    localparam int SRC_H_DEF = 480;
    localparam int BLK_DEF   = 16;
    localparam int OUT_W     = SRC_W_DEF / BLK_DEF;
    localparam int OUT_H     = SRC_H_DEF / BLK_DEF;
    localparam int ADDR_W    = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/image_resize_avg_key_falling_edge_sync.sv
// Two-flop synchronizer for the active-low start key plus a one-cycle falling-edge pulse.
module key_falling_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic fall
);

    logic sync_1_reg;
    logic sync_2_reg;
    logic prev_reg;

    // Flops idle high so an un-pressed key never produces a pulse out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1_reg <= 1'b1;
            sync_2_reg <= 1'b1;
            prev_reg   <= 1'b1;
        end else begin
            sync_1_reg <= key;
            sync_2_reg <= sync_1_reg;
            prev_reg   <= sync_2_reg;
        end
    end

    assign fall = prev_reg & ~sync_2_reg;

endmodule

// File: rtl/image_resize_avg.sv
// Reads one frame through the SDRAM read port and stores the average of every
// BLK x BLK pixel block in the out[][] register array.
module image_resize_avg
    import image_resize_avg_pkg::*;
#(
    parameter int SRC_W     = SRC_W_DEF,
    parameter int SRC_H     = SRC_H_DEF,
    parameter int BLK       = BLK_DEF,
    parameter int READ_LAT  = 2,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              KEY_2,
    input  logic [7:0]        Read_DATA2,
    output logic              start_resize,
    output logic [ADDR_W-1:0] read_addr_resize
);

    localparam int OW  = SRC_W / BLK;
    localparam int OH  = SRC_H / BLK;
    localparam int PW  = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int BXW = (OW > 1) ? $clog2(OW) : 1;
    localparam int BYW = (OH > 1) ? $clog2(OH) : 1;
    localparam int DW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [PW-1:0]  PIX_LAST   = PW'(BLK - 1);
    localparam logic [BXW-1:0] BX_LAST    = BXW'(OW - 1);
    localparam logic [BYW-1:0] BY_LAST    = BYW'(OH - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(READ_LAT - 1);

    state_t state_reg;
    state_t state_next;

    logic [PW-1:0]       pixel_x;
    logic [PW-1:0]       pixel_y;
    logic [BXW-1:0]      block_x;
    logic [BYW-1:0]      block_y;
    logic [DW-1:0]       drain_cnt_reg;
    logic [READ_LAT-1:0] vld_reg;
    logic [15:0]         acc_reg;
    logic [7:0]          out [OH][OW];

    logic              start_pulse;
    logic              issue;
    logic              last_pixel;
    logic              drain_last;
    logic              last_block;
    logic              block_done;
    logic [7:0]        block_avg;
    logic [ADDR_W-1:0] addr_calc;

    key_falling_edge_sync u_key_sync (
        .clk  (clk),
        .rst  (rst),
        .key  (KEY_2),
        .fall (start_pulse)
    );

    assign last_pixel = (pixel_x == PIX_LAST) && (pixel_y == PIX_LAST);
    assign drain_last = (drain_cnt_reg == DRAIN_LAST);
    assign last_block = (block_x == BX_LAST) && (block_y == BY_LAST);
    assign block_done = (state_reg == DRAIN) && drain_last;

    assign addr_calc = ADDR_W'(32'(BASE_ADDR)
                     + (32'(block_y) * 32'(BLK) + 32'(pixel_y)) * 32'(SRC_W)
                     + 32'(block_x) * 32'(BLK) + 32'(pixel_x));

    // The last pixel of the block is still on the bus at the drain-exit edge,
    // so it is folded in directly instead of through the accumulator.
    assign block_avg = 8'((acc_reg + {8'd0, Read_DATA2}) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_pulse) state_next = ISSUE;
            ISSUE:   if (last_pixel) state_next = DRAIN;
            DRAIN:   if (drain_last) state_next = last_block ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_resize     = 1'b0;
        issue            = 1'b0;
        read_addr_resize = '0;
        case (state_reg)
            ISSUE: begin
                start_resize     = 1'b1;
                issue            = 1'b1;
                read_addr_resize = addr_calc;
            end
            DRAIN: begin
                start_resize     = 1'b1;
                read_addr_resize = addr_calc;
            end
            default: begin
                start_resize     = 1'b0;
            end
        endcase
    end

    // Pixel/block counters: pixels advance in ISSUE, hold at the last pixel
    // through DRAIN, and roll to the next block on the drain-exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x <= '0;
            pixel_y <= '0;
            block_x <= '0;
            block_y <= '0;
        end else if (issue && !last_pixel) begin
            if (pixel_x != PIX_LAST) begin
                pixel_x <= pixel_x + PW'(1);
            end else begin
                pixel_x <= '0;
                pixel_y <= pixel_y + PW'(1);
            end
        end else if (block_done) begin
            pixel_x <= '0;
            pixel_y <= '0;
            if (block_x == BX_LAST) begin
                block_x <= '0;
                block_y <= (block_y == BY_LAST) ? '0 : block_y + BYW'(1);
            end else begin
                block_x <= block_x + BXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt_reg <= '0;
        end else if (state_reg == DRAIN) begin
            drain_cnt_reg <= drain_last ? '0 : drain_cnt_reg + DW'(1);
        end else begin
            drain_cnt_reg <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (block_done) begin
            acc_reg <= '0;
        end else if (vld_reg[READ_LAT-1]) begin
            acc_reg <= acc_reg + {8'd0, Read_DATA2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < OH; r++) begin
                for (int c = 0; c < OW; c++) begin
                    out[r][c] <= '0;
                end
            end
        end else if (block_done) begin
            out[block_y][block_x] <= block_avg;
        end
    end

endmodule

// File: tb/tb_image_resize_avg.sv
// Scoreboard bench: an SDRAM model serves frame bytes, a reference model predicts
// every read address and block average, and a monitor checks them as they appear.
module tb_image_resize_avg;
    import image_resize_avg_pkg::*;

    localparam int SRC_W    = 640;
    localparam int SRC_H    = 32;
    localparam int BLK      = 16;
    localparam int READ_LAT = 2;
    localparam int BASE     = 0;
    localparam int OW       = SRC_W / BLK;
    localparam int OH       = SRC_H / BLK;
    localparam int NPIX     = SRC_W * SRC_H;
    localparam int BLOCKS   = OW * OH;
    localparam int PERIOD   = BLK * BLK + READ_LAT;

    localparam int M_CONST = 0;
    localparam int M_RAMP  = 1;
    localparam int M_RAND  = 2;
    localparam int M_FULL  = 3;

    typedef struct {
        int by;
        int bx;
        int val;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        KEY_2;
    logic [7:0]  Read_DATA2;
    logic        start_resize;
    logic [22:0] read_addr_resize;

    logic [7:0]  img [0:NPIX-1];
    logic [22:0] rd_pipe [0:READ_LAT-1];
    int          exp_out [OH][OW];
    blk_t        exp_blk [$];
    int          exp_addr [$];

    int vectors     = 0;
    int miscompares = 0;
    int busy_cnt    = 0;
    bit mon_en      = 1'b0;

    always #5 clk = ~clk;

    image_resize_avg #(
        .SRC_W     (SRC_W),
        .SRC_H     (SRC_H),
        .BLK       (BLK),
        .READ_LAT  (READ_LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .KEY_2            (KEY_2),
        .Read_DATA2       (Read_DATA2),
        .start_resize     (start_resize),
        .read_addr_resize (read_addr_resize)
    );

    // SDRAM read-port model: data for an address appears READ_LAT cycles later.
    always @(posedge clk) begin
        rd_pipe[0] <= read_addr_resize;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign Read_DATA2 = (int'(rd_pipe[READ_LAT-1]) - BASE < NPIX)
                      ? img[int'(rd_pipe[READ_LAT-1]) - BASE] : 8'd0;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: fills the frame and queues every expected address and average.
    task automatic build_frame(input int mode);
        int cval;
        int sum;
        int last;
        cval = 600;
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                M_CONST: img[i] = cval[7:0];
                M_RAMP:  img[i] = 8'(((i % SRC_W) % BLK) * 16 + ((i / SRC_W) % BLK));
                M_RAND:  img[i] = 8'($urandom);
                default: img[i] = 8'd255;
            endcase
        end
        exp_blk.delete();
        exp_addr.delete();
        for (int by = 0; by < OH; by++) begin
            for (int bx = 0; bx < OW; bx++) begin
                sum = 0;
                for (int y = 0; y < BLK; y++) begin
                    for (int x = 0; x < BLK; x++) begin
                        last = BASE + (by * BLK + y) * SRC_W + bx * BLK + x;
                        sum += int'(img[last - BASE]);
                        exp_addr.push_back(last);
                    end
                end
                for (int d = 0; d < READ_LAT; d++) exp_addr.push_back(last);
                exp_out[by][bx] = (sum / (BLK * BLK)) % 256;
                exp_blk.push_back('{by: by, bx: bx, val: exp_out[by][bx]});
            end
        end
    endtask

    // Monitor: one address per busy cycle, one stored average per block change.
    initial begin
        int prev_by;
        int prev_bx;
        int cur_by;
        int cur_bx;
        blk_t e;
        prev_by = 0;
        prev_bx = 0;
        forever begin
            @(negedge clk);
            cur_by = int'(dut.block_y);
            cur_bx = int'(dut.block_x);
            if (mon_en && !rst) begin
                if (start_resize) begin
                    busy_cnt++;
                    if (exp_addr.size() == 0) fail_now("addr_unexpected");
                    else check("addr", int'(read_addr_resize), exp_addr.pop_front());
                end
                if (cur_by != prev_by || cur_bx != prev_bx) begin
                    if (exp_blk.size() == 0) begin
                        fail_now("blk_unexpected");
                    end else begin
                        e = exp_blk.pop_front();
                        check("blk_pos", prev_by * OW + prev_bx, e.by * OW + e.bx);
                        check("blk_val", int'(dut.out[e.by][e.bx]), e.val);
                        check("next_pix0", int'(dut.pixel_x) + int'(dut.pixel_y), 0);
                    end
                end
            end
            prev_by = cur_by;
            prev_bx = cur_bx;
        end
    end

    task automatic run_frame(input int mode, input bit repress, input bit wait_done);
        int lat;
        int n;
        build_frame(mode);
        busy_cnt = 0;
        @(posedge clk);
        #1 KEY_2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (start_resize) begin
                lat = k;
                break;
            end
        end
        check("start_latency", lat, 3);
        check("first_addr", int'(read_addr_resize), BASE);
        repeat (4) @(posedge clk);
        #1 KEY_2 = 1'b1;
        if (repress) begin
            repeat (3000) @(posedge clk);
            #1 KEY_2 = 1'b0;
            repeat (6) @(posedge clk);
            #1 KEY_2 = 1'b1;
        end
        if (wait_done) begin
            n = 0;
            while (start_resize && n < 40000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (start_resize) fail_now("frame_timeout");
            check("state_done", int'(dut.state_reg), int'(DONE));
            @(posedge clk);
            #1;
            check("state_idle", int'(dut.state_reg), int'(IDLE));
            check("idle_addr", int'(read_addr_resize), 0);
            check("busy_cycles", busy_cnt, BLOCKS * PERIOD);
            check("blk_left", exp_blk.size(), 0);
            check("addr_left", exp_addr.size(), 0);
            for (int by = 0; by < OH; by++)
                for (int bx = 0; bx < OW; bx++)
                    check("out_entry", int'(dut.out[by][bx]), exp_out[by][bx]);
            $display("frame mode %0d done: %0d busy cycles", mode, busy_cnt);
        end
    endtask

    initial begin
        rst   = 1'b1;
        KEY_2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(start_resize), 0);
        check("rst_addr", int'(read_addr_resize), 0);
        check("rst_state", int'(dut.state_reg), int'(IDLE));
        check("rst_out", int'(dut.out[OH-1][OW-1]), 0);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        // Constant 600 (88 truncated) frame, interrupted by reset in block 3.
        run_frame(M_CONST, 1'b0, 1'b0);
        repeat (3 * PERIOD + 100) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", int'(start_resize), 0);
        check("midrst_addr", int'(read_addr_resize), 0);
        check("midrst_out00", int'(dut.out[0][0]), 0);
        check("midrst_out02", int'(dut.out[0][2]), 0);
        check("midrst_bx", int'(dut.block_x), 0);
        check("midrst_state", int'(dut.state_reg), int'(IDLE));
        check("midrst_blocks_seen", exp_blk.size(), BLOCKS - 3);
        exp_blk.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        mon_en = 1'b1;
        $display("mid-frame reset applied");

        run_frame(M_RAMP, 1'b0, 1'b1);
        run_frame(M_RAND, 1'b1, 1'b1);
        run_frame(M_FULL, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
